// File: rtl/clock_pkg.sv
// Shared constants and FSM state type for the seconds-to-days/hours/mins/secs converter.
package clock_pkg;

  localparam int SEC_PER_DAY  = 86400;
  localparam int SEC_PER_HOUR = 3600;
  localparam int SEC_PER_MIN  = 60;

  typedef enum logic [2:0] {
    IDLE,
    DIV_D,
    DIV_H,
    DIV_M,
    BCD,
    DONE
  } state_t;

  // 10^n, used to size the days saturation threshold at elaboration time.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock, W steps per division.
// The first step is taken on the start edge itself, so done is seen in the
// W-th cycle and the caller can chain the next division on the following edge.
module seq_divider #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_quot, r_rem, r_div;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  w_q_in, w_r_in, w_d_in, w_q_nxt, w_r_nxt;
  logic [W:0]    w_shift, w_trial;
  logic          w_run;

  assign w_run = (r_cnt != '0) && (r_cnt != CW'(W));

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_q_in  = start ? dividend : r_quot;
    w_r_in  = start ? '0       : r_rem;
    w_d_in  = start ? divisor  : r_div;
    w_shift = {w_r_in, w_q_in[W-1]};
    w_trial = w_shift - {1'b0, w_d_in};
    if (w_trial[W]) begin
      w_r_nxt = w_shift[W-1:0];
      w_q_nxt = {w_q_in[W-2:0], 1'b0};
    end else begin
      w_r_nxt = w_trial[W-1:0];
      w_q_nxt = {w_q_in[W-2:0], 1'b1};
    end
  end

  // Operand/step registers; start always wins and restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else if (start) begin
      r_quot <= w_q_nxt;
      r_rem  <= w_r_nxt;
      r_div  <= divisor;
      r_cnt  <= CW'(1);
    end else if (w_run) begin
      r_quot <= w_q_nxt;
      r_rem  <= w_r_nxt;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign done      = (r_cnt == CW'(W));

endmodule

// File: rtl/sec_to_dhms.sv
// Converts a binary seconds count into packed-BCD days/hours/minutes/seconds.
// Three chained divisions share one divider; one double-dabble engine then
// converts the four fields in turn. Outputs change only on the DONE edge.
module sec_to_dhms
  import clock_pkg::*;
#(
  parameter int W          = 28,
  parameter int DAY_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [W-1:0]            t_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*DAY_DIGITS-1:0] days_bcd,
  output logic [7:0]              hours_bcd,
  output logic [7:0]              mins_bcd,
  output logic [7:0]              secs_bcd,
  output logic                    ovf
);

  localparam logic [63:0] DAY_MAX = pow10(DAY_DIGITS) - 64'd1;

  state_t r_state, w_next;

  logic         w_div_start, w_div_done;
  logic [W-1:0] w_div_dvd, w_div_dvs, w_quot, w_rem;

  logic [W-1:0] r_days;
  logic [11:0]  r_hrs, r_mins, r_secs;
  logic [11:0]  r_dd_src;
  logic [14:0]  r_dd_bcd;
  logic [3:0]   r_bit;
  logic [1:0]   r_fld;
  logic [15:0]  r_days_h;
  logic [7:0]   r_hrs_h, r_mins_h, r_secs_h;
  logic [11:0]  w_dd_add;
  logic [15:0]  w_dd_next;
  logic         w_dd_last, w_ovf;
  logic [4*DAY_DIGITS-1:0] w_days_fit;

  seq_divider #(.W(W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (w_div_start),
    .dividend  (w_div_dvd),
    .divisor   (w_div_dvs),
    .quotient  (w_quot),
    .remainder (w_rem),
    .done      (w_div_done)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state; each divide launches the next one on the edge it finishes.
  always_comb begin
    w_next      = r_state;
    w_div_start = 1'b0;
    w_div_dvd   = w_rem;
    w_div_dvs   = W'(SEC_PER_DAY);
    unique case (r_state)
      IDLE: begin
        w_div_dvd = t_in;
        if (start) begin
          w_div_start = 1'b1;
          w_next      = DIV_D;
        end
      end
      DIV_D: begin
        w_div_dvs = W'(SEC_PER_HOUR);
        if (w_div_done) begin
          w_div_start = 1'b1;
          w_next      = DIV_H;
        end
      end
      DIV_H: begin
        w_div_dvs = W'(SEC_PER_MIN);
        if (w_div_done) begin
          w_div_start = 1'b1;
          w_next      = DIV_M;
        end
      end
      DIV_M:   if (w_div_done) w_next = BCD;
      BCD:     if (w_dd_last && r_fld == 2'd3) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  // Add-3 then shift. Fields are below 4096, so before any shift the value is
  // below 2048 and the top digit never reaches 5; it needs no adjust.
  always_comb begin
    w_dd_add = r_dd_bcd[11:0];
    for (int i = 0; i < 3; i++) begin
      if (r_dd_bcd[4*i +: 4] >= 4'd5) w_dd_add[4*i +: 4] = r_dd_bcd[4*i +: 4] + 4'd3;
    end
    w_dd_next = {r_dd_bcd[14:12], w_dd_add, r_dd_src[11]};
  end

  assign w_dd_last = (r_bit == 4'd11);
  assign w_ovf     = (64'(r_days) > DAY_MAX);

  // Fit the four converted day digits into the configured days field width.
  generate
    if (DAY_DIGITS > 4) begin : g_days_wide
      assign w_days_fit = {{(4*DAY_DIGITS-16){1'b0}}, r_days_h};
    end else if (DAY_DIGITS == 4) begin : g_days_four
      assign w_days_fit = r_days_h;
    end else begin : g_days_narrow
      assign w_days_fit = r_days_h[4*DAY_DIGITS-1:0];
    end
  endgenerate

  // Quotient capture and the shared double-dabble sequencing over four fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_days   <= '0;
      r_hrs    <= '0;
      r_mins   <= '0;
      r_secs   <= '0;
      r_dd_src <= '0;
      r_dd_bcd <= '0;
      r_bit    <= '0;
      r_fld    <= '0;
      r_days_h <= '0;
      r_hrs_h  <= '0;
      r_mins_h <= '0;
      r_secs_h <= '0;
    end else begin
      if (r_state == DIV_D && w_div_done) r_days <= w_quot;
      if (r_state == DIV_H && w_div_done) r_hrs  <= w_quot[11:0];
      if (r_state == DIV_M && w_div_done) begin
        r_mins   <= w_quot[11:0];
        r_secs   <= w_rem[11:0];
        r_dd_src <= r_days[11:0];
        r_dd_bcd <= '0;
        r_bit    <= '0;
        r_fld    <= '0;
      end
      if (r_state == BCD) begin
        if (w_dd_last) begin
          r_bit    <= '0;
          r_fld    <= r_fld + 2'd1;
          r_dd_bcd <= '0;
          case (r_fld)
            2'd0: begin r_days_h <= w_dd_next;      r_dd_src <= r_hrs;  end
            2'd1: begin r_hrs_h  <= w_dd_next[7:0]; r_dd_src <= r_mins; end
            2'd2: begin r_mins_h <= w_dd_next[7:0]; r_dd_src <= r_secs; end
            default: r_secs_h <= w_dd_next[7:0];
          endcase
        end else begin
          r_bit    <= r_bit + 4'd1;
          r_dd_src <= {r_dd_src[10:0], 1'b0};
          r_dd_bcd <= w_dd_next[14:0];
        end
      end
    end
  end

  // Publish all fields together on the DONE edge and pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      ovf       <= 1'b0;
      days_bcd  <= '0;
      hours_bcd <= '0;
      mins_bcd  <= '0;
      secs_bcd  <= '0;
    end else begin
      done <= (r_state == DONE);
      if (r_state == DONE) begin
        ovf       <= w_ovf;
        days_bcd  <= w_ovf ? {DAY_DIGITS{4'h9}} : w_days_fit;
        hours_bcd <= r_hrs_h;
        mins_bcd  <= r_mins_h;
        secs_bcd  <= r_secs_h;
      end
    end
  end

endmodule
